// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the hardwired CPU control unit: IR field positions, opcodes,
// ALU codes, instruction classes and the sequencer state encoding.
package cpu_ctrl_pkg;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int RA_HI  = 26;
  localparam int RA_LO  = 23;
  localparam int RB_HI  = 22;
  localparam int RB_LO  = 19;
  localparam int RC_HI  = 18;
  localparam int RC_LO  = 15;

  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_ST   = 5'd1;
  localparam logic [4:0] OP_ADD  = 5'd2;
  localparam logic [4:0] OP_SUB  = 5'd3;
  localparam logic [4:0] OP_AND  = 5'd4;
  localparam logic [4:0] OP_OR   = 5'd5;
  localparam logic [4:0] OP_SHR  = 5'd6;
  localparam logic [4:0] OP_SHRA = 5'd7;
  localparam logic [4:0] OP_SHL  = 5'd8;
  localparam logic [4:0] OP_ROR  = 5'd9;
  localparam logic [4:0] OP_ROL  = 5'd10;
  localparam logic [4:0] OP_NEG  = 5'd11;
  localparam logic [4:0] OP_NOT  = 5'd12;
  localparam logic [4:0] OP_MUL  = 5'd13;
  localparam logic [4:0] OP_DIV  = 5'd14;
  localparam logic [4:0] OP_MFHI = 5'd15;
  localparam logic [4:0] OP_MFLO = 5'd16;
  localparam logic [4:0] OP_IN   = 5'd17;
  localparam logic [4:0] OP_OUT  = 5'd18;
  localparam logic [4:0] OP_NOP  = 5'd19;
  localparam logic [4:0] OP_HALT = 5'd20;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_SHR  = 4'd4,
    ALU_SHRA = 4'd5,
    ALU_SHL  = 4'd6,
    ALU_ROR  = 4'd7,
    ALU_ROL  = 4'd8,
    ALU_MUL  = 4'd9,
    ALU_DIV  = 4'd10,
    ALU_NEG  = 4'd11,
    ALU_NOT  = 4'd12,
    ALU_INC  = 4'd13
  } alu_op_t;

  typedef enum logic [3:0] {
    CLS_ALU3,
    CLS_UNARY,
    CLS_MULDIV,
    CLS_LD,
    CLS_ST,
    CLS_MFHI,
    CLS_MFLO,
    CLS_IN,
    CLS_OUT,
    CLS_NOP,
    CLS_HALT
  } instr_class_t;

  typedef enum logic [3:0] {
    ST_F0,
    ST_F1,
    ST_F2,
    ST_F3,
    ST_E0,
    ST_E1,
    ST_E2,
    ST_E3,
    ST_HALT
  } state_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Control bundle between sequencer (master) and datapath (slave): IR/mem_ready in,
// every datapath strobe out. Single cycle, no backpressure beyond mem_ready.
interface control_sequencer_if;
  logic [31:0] ir;
  logic        mem_ready;
  logic        PCin, PCout, IRin, MARin;
  logic        MDRin, MDRout, read, mem_write;
  logic        HIin, HIout, LOin, LOout;
  logic        Yin, Zin, ZHighout, ZLowout;
  logic        InPortout, OutPortin;
  logic        Rin, Rout;
  logic [3:0]  reg_select;
  logic [3:0]  ALU_operation;
  logic        run;

  modport master (
    input  ir, mem_ready,
    output PCin, PCout, IRin, MARin, MDRin, MDRout, read, mem_write,
    output HIin, HIout, LOin, LOout, Yin, Zin, ZHighout, ZLowout,
    output InPortout, OutPortin, Rin, Rout, reg_select, ALU_operation, run
  );

  modport slave (
    output ir, mem_ready,
    input  PCin, PCout, IRin, MARin, MDRin, MDRout, read, mem_write,
    input  HIin, HIout, LOin, LOout, Yin, Zin, ZHighout, ZLowout,
    input  InPortout, OutPortin, Rin, Rout, reg_select, ALU_operation, run
  );
endinterface

// File: rtl/instr_class_decode.sv
// Combinational opcode classifier: opcode -> instruction class and ALU code.
// Zero latency, no backpressure; unused opcodes classify as nop.
module instr_class_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0]   opcode,
  output instr_class_t iclass,
  output alu_op_t      alu_op
);

  always_comb begin
    iclass = CLS_NOP;
    alu_op = ALU_ADD;
    case (opcode)
      OP_LD:   iclass = CLS_LD;
      OP_ST:   iclass = CLS_ST;
      OP_ADD:  begin iclass = CLS_ALU3;   alu_op = ALU_ADD;  end
      OP_SUB:  begin iclass = CLS_ALU3;   alu_op = ALU_SUB;  end
      OP_AND:  begin iclass = CLS_ALU3;   alu_op = ALU_AND;  end
      OP_OR:   begin iclass = CLS_ALU3;   alu_op = ALU_OR;   end
      OP_SHR:  begin iclass = CLS_ALU3;   alu_op = ALU_SHR;  end
      OP_SHRA: begin iclass = CLS_ALU3;   alu_op = ALU_SHRA; end
      OP_SHL:  begin iclass = CLS_ALU3;   alu_op = ALU_SHL;  end
      OP_ROR:  begin iclass = CLS_ALU3;   alu_op = ALU_ROR;  end
      OP_ROL:  begin iclass = CLS_ALU3;   alu_op = ALU_ROL;  end
      OP_NEG:  begin iclass = CLS_UNARY;  alu_op = ALU_NEG;  end
      OP_NOT:  begin iclass = CLS_UNARY;  alu_op = ALU_NOT;  end
      OP_MUL:  begin iclass = CLS_MULDIV; alu_op = ALU_MUL;  end
      OP_DIV:  begin iclass = CLS_MULDIV; alu_op = ALU_DIV;  end
      OP_MFHI: iclass = CLS_MFHI;
      OP_MFLO: iclass = CLS_MFLO;
      OP_IN:   iclass = CLS_IN;
      OP_OUT:  iclass = CLS_OUT;
      OP_HALT: iclass = CLS_HALT;
      default: iclass = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer: Moore strobes decoded from state and IR, one step
// per cycle; memory steps stall on mem_ready, HALT holds until clear.
module control_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic                clock,
  input  logic                clear,
  control_sequencer_if.master bus
);

  state_t       state;
  instr_class_t iclass;
  alu_op_t      alu_op;
  logic [3:0]   ra, rb, rc;
  logic         mem_wait;
  logic         last_step;
  logic         unused_ir_bits;

  assign ra = bus.ir[RA_HI:RA_LO];
  assign rb = bus.ir[RB_HI:RB_LO];
  assign rc = bus.ir[RC_HI:RC_LO];
  assign unused_ir_bits = ^bus.ir[RC_LO-1:0];

  instr_class_decode u_decode (
    .opcode (bus.ir[OPC_HI:OPC_LO]),
    .iclass (iclass),
    .alu_op (alu_op)
  );

  // Steps that stall on memory; the IR only matters once we are in E-steps.
  assign mem_wait = (state == ST_F2)
                 || (state == ST_E1 && iclass == CLS_LD)
                 || (state == ST_E2 && iclass == CLS_ST);

  always_comb begin
    last_step = 1'b0;
    case (iclass)
      CLS_ALU3, CLS_LD, CLS_ST: last_step = (state == ST_E2);
      CLS_UNARY:                last_step = (state == ST_E1);
      CLS_MULDIV:               last_step = (state == ST_E3);
      default:                  last_step = (state == ST_E0);
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state <= ST_F0;
    end else if (mem_wait && !bus.mem_ready) begin
      state <= state;
    end else if (last_step) begin
      state <= (iclass == CLS_HALT) ? ST_HALT : ST_F0;
    end else begin
      case (state)
        ST_F0:   state <= ST_F1;
        ST_F1:   state <= ST_F2;
        ST_F2:   state <= ST_F3;
        ST_F3:   state <= ST_E0;
        ST_E0:   state <= ST_E1;
        ST_E1:   state <= ST_E2;
        ST_E2:   state <= ST_E3;
        ST_HALT: state <= ST_HALT;
        default: state <= ST_F0;
      endcase
    end
  end

  always_comb begin
    bus.PCin = 1'b0;      bus.PCout = 1'b0;     bus.IRin = 1'b0;      bus.MARin = 1'b0;
    bus.MDRin = 1'b0;     bus.MDRout = 1'b0;    bus.read = 1'b0;      bus.mem_write = 1'b0;
    bus.HIin = 1'b0;      bus.HIout = 1'b0;     bus.LOin = 1'b0;      bus.LOout = 1'b0;
    bus.Yin = 1'b0;       bus.Zin = 1'b0;       bus.ZHighout = 1'b0;  bus.ZLowout = 1'b0;
    bus.InPortout = 1'b0; bus.OutPortin = 1'b0; bus.Rin = 1'b0;       bus.Rout = 1'b0;
    bus.reg_select = 4'd0;
    bus.ALU_operation = ALU_ADD;
    bus.run = !clear && (state != ST_HALT);
    if (!clear) begin
      case (state)
        ST_F0: begin bus.PCout = 1'b1; bus.MARin = 1'b1; bus.ALU_operation = ALU_INC; bus.Zin = 1'b1; end
        ST_F1: begin bus.ZLowout = 1'b1; bus.PCin = 1'b1; end
        ST_F2: begin bus.read = 1'b1; bus.MDRin = 1'b1; end
        ST_F3: begin bus.MDRout = 1'b1; bus.IRin = 1'b1; end
        ST_E0: begin
          case (iclass)
            CLS_ALU3:   begin bus.Rout = 1'b1; bus.reg_select = rb; bus.Yin = 1'b1; end
            CLS_UNARY:  begin bus.Rout = 1'b1; bus.reg_select = rb; bus.ALU_operation = alu_op; bus.Zin = 1'b1; end
            CLS_MULDIV: begin bus.Rout = 1'b1; bus.reg_select = ra; bus.Yin = 1'b1; end
            CLS_LD,
            CLS_ST:     begin bus.Rout = 1'b1; bus.reg_select = rb; bus.MARin = 1'b1; end
            CLS_MFHI:   begin bus.HIout = 1'b1; bus.Rin = 1'b1; bus.reg_select = ra; end
            CLS_MFLO:   begin bus.LOout = 1'b1; bus.Rin = 1'b1; bus.reg_select = ra; end
            CLS_IN:     begin bus.InPortout = 1'b1; bus.Rin = 1'b1; bus.reg_select = ra; end
            CLS_OUT:    begin bus.Rout = 1'b1; bus.reg_select = ra; bus.OutPortin = 1'b1; end
            default:    ;
          endcase
        end
        ST_E1: begin
          case (iclass)
            CLS_ALU3:   begin bus.Rout = 1'b1; bus.reg_select = rc; bus.ALU_operation = alu_op; bus.Zin = 1'b1; end
            CLS_UNARY:  begin bus.ZLowout = 1'b1; bus.Rin = 1'b1; bus.reg_select = ra; end
            CLS_MULDIV: begin bus.Rout = 1'b1; bus.reg_select = rb; bus.ALU_operation = alu_op; bus.Zin = 1'b1; end
            CLS_LD:     begin bus.read = 1'b1; bus.MDRin = 1'b1; end
            CLS_ST:     begin bus.Rout = 1'b1; bus.reg_select = ra; bus.MDRin = 1'b1; end
            default:    ;
          endcase
        end
        ST_E2: begin
          case (iclass)
            CLS_ALU3:   begin bus.ZLowout = 1'b1; bus.Rin = 1'b1; bus.reg_select = ra; end
            CLS_MULDIV: begin bus.ZLowout = 1'b1; bus.LOin = 1'b1; end
            CLS_LD:     begin bus.MDRout = 1'b1; bus.Rin = 1'b1; bus.reg_select = ra; end
            CLS_ST:     bus.mem_write = 1'b1;
            default:    ;
          endcase
        end
        ST_E3: begin
          if (iclass == CLS_MULDIV) begin
            bus.ZHighout = 1'b1;
            bus.HIin = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit driving the bus-based CPU datapath. It consumes the instruction register contents and a memory-ready handshake, and emits every datapath strobe (register select, bus-out enables, register load enables, ALU operation, memory read/write) cycle by cycle. It runs fetch/execute until a `halt` instruction and sits beside the datapath in the CPU top level.

## Interface
- Parameters: none.
- `clock` in 1: rising-edge clock.
- `clear` in 1: synchronous, active-high reset.
- `ir` in 32: IR register contents. Valid from the first execute step onward.
- `mem_ready` in 1: memory completion for the current `read` or `mem_write`. Sampled at the rising edge.
- `PCin`, `PCout`, `IRin`, `MARin` out 1 each: datapath load and bus-out strobes.
- `MDRin`, `MDRout`, `read` out 1 each: MDR strobes. `read=1` selects memory data into the MDR, `read=0` selects the bus.
- `mem_write` out 1: memory write request. Address comes from MAR, data from MDR.
- `HIin`, `HIout`, `LOin`, `LOout` out 1 each: HI/LO strobes.
- `Yin`, `Zin`, `ZHighout`, `ZLowout` out 1 each: ALU operand and result strobes.
- `InPortout`, `OutPortin` out 1 each: I/O port strobes. The top level ties `Cin` and `Cout` to 0.
- `Rin`, `Rout` out 1 each: general-register load and drive.
- `reg_select` out 4: general register index used with `Rin`/`Rout`.
- `ALU_operation` out 4: ALU op code.
- `run` out 1: high while sequencing, low when halted or in clear.

## Operation
- IR fields:
  - `ir[31:27]` opcode
  - `ir[26:23]` ra
  - `ir[22:19]` rb
  - `ir[18:15]` rc
- ALU codes: ADD 0, SUB 1, AND 2, OR 3, SHR 4, SHRA 5, SHL 6, ROR 7, ROL 8, MUL 9, DIV 10, NEG 11, NOT 12, INC 13.
- Opcodes:
  - 0 ld ra,(rb)
  - 1 st (rb),ra
  - 2–10 ra←rb op rc, with op = ALU code (opcode−2)
  - 11 neg, 12 not: ra←op rb
  - 13 mul, 14 div: HI/LO←ra op rb
  - 15 mfhi, 16 mflo, 17 in ra, 18 out ra, 19 nop, 20 halt
  - 21–31 behave as nop.
- Fetch:
  - F0: PCout, MARin, ALU=INC, Zin.
  - F1: ZLowout, PCin.
  - F2: read, MDRin; hold until `mem_ready`.
  - F3: MDRout, IRin.
- Execute steps E0.. (all strobes not listed are 0):
  - ALU3: E0 Rout rb, Yin; E1 Rout rc, ALU op, Zin; E2 ZLowout, Rin ra.
  - Unary: E0 Rout rb, op, Zin; E1 ZLowout, Rin ra.
  - mul/div: E0 Rout ra, Yin; E1 Rout rb, op, Zin; E2 ZLowout, LOin; E3 ZHighout, HIin.
  - ld: E0 Rout rb, MARin; E1 read, MDRin, wait `mem_ready`; E2 MDRout, Rin ra.
  - st: E0 Rout rb, MARin; E1 Rout ra, MDRin (read=0); E2 mem_write, wait `mem_ready`.
  - mfhi/mflo: E0 HIout or LOout, Rin ra.
  - in: E0 InPortout, Rin ra.
  - out: E0 Rout ra, OutPortin.
  - nop: single E0 with no strobes.
- After the last execute step, return to F0.
- halt: enter HALT. `run=0`, all strobes 0, and HALT is held until `clear`.
- Only one bus-out strobe is active in any cycle (the bus is one-hot).
- `reg_select` is 0 whenever `Rin` and `Rout` are both 0.

## Timing
- Moore outputs decoded from the state register and `ir`. No output depends on `mem_ready` combinationally.
- Wait states (F2, ld E1, st E2):
  - The state advances at the edge where `mem_ready=1`.
  - The strobes stay constant during the wait.
  - A zero-wait memory (`mem_ready` already high) costs exactly one cycle.
- Cycle counts at zero wait, fetch included: ALU3 7, unary 6, mul/div 8, ld 7, st 7, mfhi/in/out/nop 5, halt 5 then stop.
- `clear` at an edge sends the state to F0 regardless of the current state, including a pending wait.
- While `clear` is high, all outputs are forced to 0 and `run=0`.
- In the first cycle after `clear` deasserts, F0 strobes are active.
- `ir` is sampled only in E-steps. An `ir` change during fetch has no effect.

## Structure
- Package `cpu_ctrl_pkg` holds the opcode constants, ALU op codes, IR field bit positions, and the state encoding (F0–F3, E0–E3, HALT).
- Sub-module `instr_class_decode` is a combinational classifier: opcode → class (ALU3, UNARY, MULDIV, LD, ST, MFHI, MFLO, IN, OUT, NOP, HALT) plus the ALU code.
- The sequencer is the single state register plus the output decode.

## Test plan
- **Reset + fetch:** `clear` 1 cycle, `mem_ready=1`. Expect F0: PCout=MARin=Zin=1, ALU_operation=13. Next cycle PCin=ZLowout=1. Then read=MDRin=1. Then MDRout=IRin=1.
- **add:** `ir`: opcode 2, ra=3, rb=1, rc=2. Expect E0 Rout, reg_select=1, Yin. E1 Rout, reg_select=2, ALU_operation=0, Zin. E2 ZLowout, Rin, reg_select=3. Back to F0 at cycle 7.
- **Wait states:** `mem_ready` low for 3 cycles during ld E1. read=MDRin=1 is held for 4 cycles, then E2 MDRout, Rin with reg_select=ra.
- **st:** opcode 1, ra=5, rb=6. Expect E1 Rout, reg_select=5, MDRin, read=0. E2 mem_write=1 until `mem_ready`.
- **mul then mfhi:** E2 LOin, E3 HIin, ALU_operation=9. The mfhi E0 shows HIout, Rin.
- **halt + mid-op clear:** halt → `run=0` and all strobes 0 for 10 cycles. `clear` during an F2 wait → F0 on the next cycle with `read=0`.
